// File: rtl/scan_chain_loader_pkg.sv
// Shared types and widths for the scan chain loader.
package scan_loader_pkg;
  localparam int BYTE_W    = 8;
  localparam int BIT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IN = 2'd1,
    SHIFT   = 2'd2,
    RUN     = 2'd3
  } state_t;
endpackage

// File: rtl/scan_chain_loader_if.sv
// Host byte stream: bytes in to the chain, readback bytes out.
interface scan_chain_loader_if;
  import scan_loader_pkg::*;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/scan_byte_shifter.sv
// One-byte serializer/deserializer: MSB-first tx shift, LSB-in rx capture.
module scan_byte_shifter
  import scan_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [BYTE_W-1:0] load_data,
  input  logic              shift_en,
  input  logic              shift_in_bit,
  output logic              tx_msb,
  output logic [BYTE_W-1:0] rx_data,
  output logic              last_bit
);
  logic [BYTE_W-1:0]    tx_buf;
  logic [BYTE_W-1:0]    rx_buf;
  logic [BIT_CNT_W-1:0] bit_cnt;

  // Parallel load of tx byte, otherwise shift both buffers one bit per enabled cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_buf  <= '0;
      rx_buf  <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      tx_buf  <= load_data;
      bit_cnt <= '0;
    end else if (shift_en) begin
      tx_buf  <= {tx_buf[BYTE_W-2:0], 1'b0};
      rx_buf  <= {rx_buf[BYTE_W-2:0], shift_in_bit};
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign tx_msb   = tx_buf[BYTE_W-1];
  assign rx_data  = rx_buf;
  assign last_bit = &bit_cnt;
endmodule

// File: rtl/scan_chain_loader.sv
// Host-side scan loader: shifts a byte image into the target chain while
// returning the displaced image, and gates the processor run enable.
module scan_chain_loader
  import scan_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 288,
  parameter int CNT_W     = $clog2(CHAIN_LEN/8+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic                  run_start,
  input  logic                  run_stop,
  scan_chain_loader_if.slave    host,
  output logic                  scan_enable,
  output logic                  scan_in,
  input  logic                  scan_out,
  output logic                  proc_en,
  input  logic                  halt,
  output logic                  busy,
  output logic                  load_done,
  output logic                  run_done
);
  localparam int              NUM_BYTES = CHAIN_LEN / BYTE_W;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

  if ((CHAIN_LEN % BYTE_W) != 0 || CHAIN_LEN < BYTE_W) begin : g_len_chk
    $error("CHAIN_LEN must be a positive multiple of 8");
  end

  state_t           state;
  logic [CNT_W-1:0] byte_cnt;
  logic             out_valid_q;
  logic             accept;
  logic             tx_msb;
  logic             last_bit;

  // A new byte is only taken once the previous readback byte has drained,
  // so the rx buffer can double as the out_data holding register.
  assign host.in_ready  = (state == WAIT_IN) && !out_valid_q;
  assign accept         = host.in_ready && host.in_valid;
  assign host.out_valid = out_valid_q;
  assign scan_in        = scan_enable & tx_msb;
  assign busy           = (state != IDLE) || out_valid_q;

  scan_byte_shifter u_shifter (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (accept),
    .load_data    (host.in_data),
    .shift_en     (scan_enable),
    .shift_in_bit (scan_out),
    .tx_msb       (tx_msb),
    .rx_data      (host.out_data),
    .last_bit     (last_bit)
  );

  // Control FSM with registered pin outputs and done pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      out_valid_q <= 1'b0;
      scan_enable <= 1'b0;
      proc_en     <= 1'b0;
      load_done   <= 1'b0;
      run_done    <= 1'b0;
    end else begin
      load_done <= 1'b0;
      run_done  <= 1'b0;
      if (out_valid_q && host.out_ready) out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state    <= WAIT_IN;
            byte_cnt <= '0;
          end else if (run_start) begin
            state   <= RUN;
            proc_en <= 1'b1;
          end
        end
        WAIT_IN: begin
          if (accept) begin
            state       <= SHIFT;
            scan_enable <= 1'b1;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            scan_enable <= 1'b0;
            out_valid_q <= 1'b1;
            byte_cnt    <= byte_cnt + 1'b1;
            if (byte_cnt == LAST_BYTE) begin
              state     <= IDLE;
              load_done <= 1'b1;
            end else begin
              state <= WAIT_IN;
            end
          end
        end
        RUN: begin
          if (halt || run_stop) begin
            state    <= IDLE;
            proc_en  <= 1'b0;
            run_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scan_chain_loader.sv
// Directed bench: byte-vector table against a shift-register model of the target chain.
module tb_scan_chain_loader;
  import scan_loader_pkg::*;

  localparam int CHAIN_LEN = 288;
  localparam int NB        = CHAIN_LEN / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_start = 1'b0, run_start = 1'b0, run_stop = 1'b0, halt = 1'b0;
  logic scan_enable, scan_in, scan_out, proc_en, busy, load_done, run_done;

  scan_chain_loader_if hif();

  scan_chain_loader #(.CHAIN_LEN(CHAIN_LEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .run_start   (run_start),
    .run_stop    (run_stop),
    .host        (hif),
    .scan_enable (scan_enable),
    .scan_in     (scan_in),
    .scan_out    (scan_out),
    .proc_en     (proc_en),
    .halt        (halt),
    .busy        (busy),
    .load_done   (load_done),
    .run_done    (run_done)
  );

  always #5 clk = ~clk;

  // Target chain model: scan_in enters at bit 0, scan_out leaves from the top
  logic [CHAIN_LEN-1:0] chain;
  logic                 pre_req = 1'b0;
  logic [7:0]           pre_val = 8'h00;
  always @(posedge clk) begin
    if (pre_req) chain <= {NB{pre_val}};
    else if (scan_enable) chain <= {chain[CHAIN_LEN-2:0], scan_in};
  end
  assign scan_out = chain[CHAIN_LEN-1];

  // Monitors sampled mid-cycle
  int se_cnt = 0, ld_cnt = 0, rd_cnt = 0, conflict = 0;
  logic [7:0] rx_log[$];
  always @(negedge clk) begin
    if (scan_enable) se_cnt++;
    if (load_done) ld_cnt++;
    if (run_done) rd_cnt++;
    if (scan_enable && proc_en) conflict++;
    if (hif.out_valid && hif.out_ready) rx_log.push_back(hif.out_data);
  end

  typedef struct {
    logic [7:0] din;
    logic [7:0] dexp;
  } vec_t;
  vec_t vec[2*NB];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_scan_enable"}, scan_enable, 0);
    chk({nm, "_scan_in"}, scan_in, 0);
    chk({nm, "_proc_en"}, proc_en, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_load_done"}, load_done, 0);
    chk({nm, "_run_done"}, run_done, 0);
    chk({nm, "_in_ready"}, hif.in_ready, 0);
    chk({nm, "_out_valid"}, hif.out_valid, 0);
    chk({nm, "_out_data"}, hif.out_data, 0);
  endtask

  task automatic preload(input logic [7:0] v);
    pre_val = v;
    pre_req = 1'b1;
    tick;
    pre_req = 1'b0;
  endtask

  task automatic wait_in_ready(output bit ok);
    int g;
    g = 0;
    while (!hif.in_ready && g < 200) begin tick; g++; end
    ok = hif.in_ready;
    if (!ok) chk("in_ready_timeout", 0, 1);
  endtask

  // Full image load of table rows base..base+NB-1, optional readback stall after byte 0
  task automatic run_load(input int base, input bit stall);
    int se0, ld0, rx0, g, bad;
    bit ok;
    logic [7:0] held;
    se0 = se_cnt; ld0 = ld_cnt; rx0 = rx_log.size();
    load_start = 1'b1; tick; load_start = 1'b0;
    for (int b = 0; b < NB; b++) begin
      wait_in_ready(ok);
      if (!ok) return;
      hif.in_data = vec[base+b].din; hif.in_valid = 1'b1; tick; hif.in_valid = 1'b0;
      if (stall && b == 0) begin
        hif.out_ready = 1'b0;
        g = 0;
        while (!hif.out_valid && g < 50) begin tick; g++; end
        chk("stall_out_valid", hif.out_valid, 1);
        held = hif.out_data; bad = 0;
        repeat (20) begin
          if (hif.in_ready || scan_enable || !hif.out_valid || hif.out_data !== held) bad++;
          tick;
        end
        chk("stall_frozen", bad, 0);
        hif.out_ready = 1'b1;
      end
    end
    g = 0;
    while (busy && g < 200) begin tick; g++; end
    chk("load_idle", busy, 0);
    chk("scan_enable_cycles", se_cnt - se0, CHAIN_LEN);
    chk("load_done_pulses", ld_cnt - ld0, 1);
    chk("readback_count", rx_log.size() - rx0, NB);
    for (int b = 0; b < NB; b++) begin
      if (rx0 + b < rx_log.size())
        chk($sformatf("readback[%0d]", b), rx_log[rx0+b], vec[base+b].dexp);
      chk($sformatf("chain_byte[%0d]", b), chain[CHAIN_LEN-1-8*b -: 8], vec[base+b].din);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pc, rd0;
    bit ok;
    for (int i = 0; i < NB; i++) begin
      vec[i]    = '{din: 8'(i), dexp: 8'hA5};
      vec[NB+i] = '{din: 8'hFF, dexp: 8'(i)};
    end
    hif.in_data = '0; hif.in_valid = 1'b0; hif.out_ready = 1'b1;

    repeat (2) tick;
    check_idle("reset");
    rst_n = 1'b1; tick;

    // Image swap: A5 image out, 0x00..0x23 in; then FF in with stalled readback
    preload(8'hA5);
    run_load(0, 1'b0);
    run_load(NB, 1'b1);

    // Run until halt after 15 cycles
    rd0 = rd_cnt;
    run_start = 1'b1; tick; run_start = 1'b0;
    pc = 0;
    for (int i = 0; i < 40; i++) begin
      if (!proc_en) break;
      pc++;
      if (pc == 15) halt = 1'b1;
      tick;
    end
    chk("run_cycles", pc, 15);
    chk("run_done_pulse", run_done, 1);
    halt = 1'b0; tick;
    chk("run_done_cleared", run_done, 0);
    chk("run_done_once", rd_cnt - rd0, 1);

    // halt already high on entry: single-cycle RUN
    halt = 1'b1; run_start = 1'b1; tick; run_start = 1'b0;
    chk("halt_entry_proc_en", proc_en, 1);
    tick;
    chk("halt_entry_exit", proc_en, 0);
    chk("halt_entry_run_done", run_done, 1);
    halt = 1'b0; tick;

    // run_stop forces exit
    run_start = 1'b1; tick; run_start = 1'b0; tick;
    chk("run_stop_before", proc_en, 1);
    run_stop = 1'b1; tick; run_stop = 1'b0;
    chk("run_stop_after", proc_en, 0);
    tick;

    // load and run same cycle: load wins; run during SHIFT ignored; reset mid-shift
    load_start = 1'b1; run_start = 1'b1; tick; load_start = 1'b0; run_start = 1'b0;
    chk("both_no_run", proc_en, 0);
    chk("both_loading", hif.in_ready, 1);
    for (int b = 0; b <= 10; b++) begin
      wait_in_ready(ok);
      if (!ok) break;
      hif.in_data = 8'(8'h40 + b); hif.in_valid = 1'b1; tick; hif.in_valid = 1'b0;
      if (b == 0) begin
        run_start = 1'b1; tick; run_start = 1'b0;
        chk("run_in_shift", proc_en, 0);
      end
      if (b == 10) begin
        repeat (4) tick;
        chk("mid_shift_active", scan_enable, 1);
        #2 rst_n = 1'b0;
        #1 check_idle("async_reset");
      end
    end
    tick; rst_n = 1'b1; tick;

    preload(8'hA5);
    run_load(0, 1'b0);
    chk("no_scan_proc_overlap", conflict, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
